// File: rtl/tour_cmd_arb.sv
// tour_cmd_arb: owns the cmd/cmd_rdy input of cmd_proc. In IDLE the UART
// command path is passed straight through; after start_tour it replays the
// solved knight's tour from TourLogic, one vertical and one horizontal
// command per move, and produces the response byte for each command.
//
// Handshake semantics (both directions): a command is offered while cmd_rdy
// is high and is taken in the cycle the consumer asserts clr_cmd_rdy; the
// offer drops on the following edge. Command completion is signalled by a
// send_resp pulse, which is only acted on while the arbiter is waiting for it.
module tour_cmd_arb #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy,
  output logic             tour_err,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATCH   = 3'd1,
    VERT    = 3'd2,
    VERT_WT = 3'd3,
    HORZ    = 3'd4,
    HORZ_WT = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  localparam logic [3:0] OP_VERT = 4'h4;
  localparam logic [3:0] OP_HORZ = 4'h5;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_POS  = 8'h5A;

  state_t           r_state;
  logic [IDX_W-1:0] r_mv_indx;
  logic [7:0]       r_move;
  logic             r_tour_err;

  logic [2:0]  w_sel;
  logic        w_dx_neg;
  logic [1:0]  w_dx_mag;
  logic        w_dy_neg;
  logic [1:0]  w_dy_mag;
  logic [15:0] w_vert_cmd;
  logic [15:0] w_horz_cmd;
  logic        w_last;

  assign w_last = (r_mv_indx == LAST_IDX);

  // Tour sequencing: latch each move, then walk the vertical and horizontal
  // command/response handshakes before advancing to the next index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mv_indx  <= '0;
      r_move     <= '0;
      r_tour_err <= 1'b0;
    end else begin
      r_tour_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_tour) begin
            r_mv_indx <= '0;
            r_state   <= LATCH;
          end
        end
        LATCH: begin
          // mv_indx has been stable for a full cycle, so move is valid here.
          r_move <= move;
          if (move == 8'h00) begin
            r_tour_err <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_state <= VERT;
          end
        end
        VERT: begin
          if (clr_cmd_rdy) r_state <= VERT_WT;
        end
        VERT_WT: begin
          if (send_resp) r_state <= HORZ;
        end
        HORZ: begin
          if (clr_cmd_rdy) r_state <= HORZ_WT;
        end
        HORZ_WT: begin
          if (send_resp) begin
            if (w_last) begin
              r_mv_indx <= '0;
              r_state   <= IDLE;
            end else begin
              r_mv_indx <= r_mv_indx + 1'b1;
              r_state   <= LATCH;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Pick the lowest set bit of the latched move (multi-hot tolerated).
  always_comb begin
    w_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_move[i]) w_sel = 3'(i);
    end
  end

  // Knight offset for the selected move, as sign plus magnitude per axis.
  always_comb begin
    w_dx_neg = 1'b0;
    w_dx_mag = 2'd0;
    w_dy_neg = 1'b0;
    w_dy_mag = 2'd0;
    case (w_sel)
      3'd0: begin w_dx_neg = 1'b0; w_dx_mag = 2'd1; w_dy_neg = 1'b0; w_dy_mag = 2'd2; end
      3'd1: begin w_dx_neg = 1'b1; w_dx_mag = 2'd1; w_dy_neg = 1'b0; w_dy_mag = 2'd2; end
      3'd2: begin w_dx_neg = 1'b1; w_dx_mag = 2'd2; w_dy_neg = 1'b0; w_dy_mag = 2'd1; end
      3'd3: begin w_dx_neg = 1'b1; w_dx_mag = 2'd2; w_dy_neg = 1'b1; w_dy_mag = 2'd1; end
      3'd4: begin w_dx_neg = 1'b1; w_dx_mag = 2'd1; w_dy_neg = 1'b1; w_dy_mag = 2'd2; end
      3'd5: begin w_dx_neg = 1'b0; w_dx_mag = 2'd1; w_dy_neg = 1'b1; w_dy_mag = 2'd2; end
      3'd6: begin w_dx_neg = 1'b0; w_dx_mag = 2'd2; w_dy_neg = 1'b1; w_dy_mag = 2'd1; end
      3'd7: begin w_dx_neg = 1'b0; w_dx_mag = 2'd2; w_dy_neg = 1'b0; w_dy_mag = 2'd1; end
      default: begin end
    endcase
  end

  assign w_vert_cmd = {OP_VERT, (w_dy_neg ? HEAD_S : HEAD_N), {2'b00, w_dy_mag}};
  assign w_horz_cmd = {OP_HORZ, (w_dx_neg ? HEAD_W : HEAD_E), {2'b00, w_dx_mag}};

  // Moore output decode; IDLE forwards the UART path combinationally.
  always_comb begin
    cmd              = 16'h0000;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_POS;
    case (r_state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
      end
      LATCH: begin
        // No command is presented while the next move is being fetched.
        cmd = 16'h0000;
      end
      VERT: begin
        cmd     = w_vert_cmd;
        cmd_rdy = 1'b1;
      end
      VERT_WT: begin
        cmd  = w_vert_cmd;
        resp = RESP_POS;
      end
      HORZ: begin
        cmd     = w_horz_cmd;
        cmd_rdy = 1'b1;
      end
      HORZ_WT: begin
        cmd  = w_horz_cmd;
        resp = w_last ? RESP_DONE : RESP_POS;
      end
      default: begin end
    endcase
  end

  assign mv_indx   = r_mv_indx;
  assign tour_busy = (r_state != IDLE);
  assign tour_err  = r_tour_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tour_cmd_arb.sv
// Bench for tour_cmd_arb: TourLogic is a move table indexed by mv_indx,
// cmd_proc is a task that takes each command and acknowledges it after a
// random delay. Expected commands/responses come from an independent offset
// table and are queued before each tour is started.
module tb_tour_cmd_arb;

  localparam int NUM_MOVES = 24;
  localparam int IDX_W     = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic             start_tour = 1'b0;
  logic [7:0]       move;
  logic [IDX_W-1:0] mv_indx;
  logic [15:0]      cmd_UART = 16'h0000;
  logic             cmd_rdy_UART = 1'b0;
  logic             clr_cmd_rdy_UART;
  logic [15:0]      cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy = 1'b0;
  logic             send_resp = 1'b0;
  logic [7:0]       resp;
  logic             tour_busy;
  logic             tour_err;
  logic [2:0]       dbg_state;

  logic [7:0] tour_mem [32];
  assign move = tour_mem[mv_indx];

  tour_cmd_arb #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
    .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
    .tour_busy(tour_busy), .tour_err(tour_err), .dbg_state(dbg_state)
  );

  localparam logic [2:0] S_IDLE = 3'd0, S_LATCH = 3'd1, S_VERT = 3'd2,
                         S_VERT_WT = 3'd3, S_HORZ = 3'd4, S_HORZ_WT = 3'd5;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_resp_q[$];
  logic        mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference offsets per move bit (dx, dy).
  int dx_tab[8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dy_tab[8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  function automatic int low_bit(input logic [7:0] m);
    int b = 0;
    for (int i = 7; i >= 0; i--) if (m[i]) b = i;
    return b;
  endfunction

  function automatic logic [15:0] model_vert(input logic [7:0] m);
    int dy = dy_tab[low_bit(m)];
    int mag = (dy < 0) ? -dy : dy;
    return {4'h4, (dy > 0) ? 8'h00 : 8'h7F, 4'(mag)};
  endfunction

  function automatic logic [15:0] model_horz(input logic [7:0] m);
    int dx = dx_tab[low_bit(m)];
    int mag = (dx < 0) ? -dx : dx;
    return {4'h5, (dx > 0) ? 8'hBF : 8'h3F, 4'(mag)};
  endfunction

  // Queue the expected traffic of a full tour built from tour_mem.
  task automatic push_tour();
    for (int i = 0; i < NUM_MOVES; i++) begin
      exp_q.push_back(model_vert(tour_mem[i]));
      exp_q.push_back(model_horz(tour_mem[i]));
      exp_resp_q.push_back(8'h5A);
      exp_resp_q.push_back((i == NUM_MOVES - 1) ? 8'hA5 : 8'h5A);
    end
  endtask

  // UART path must stay blocked while a tour owns the command port.
  always @(negedge clk) begin
    if (mon_en && tour_busy)
      check("uart_blocked", {30'd0, cmd == 16'h4001, clr_cmd_rdy_UART}, 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (cmd_rdy !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("rdy_timeout", {31'd0, n < 40}, 32'd1);
  endtask

  // cmd_proc model: accept one command, ack after 1..20 clocks.
  task automatic serve();
    logic [15:0] e;
    logic [7:0]  er;
    wait_rdy();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check("cmd", {16'd0, cmd}, {16'd0, e});
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    #1;
    check("rdy_drop", {31'd0, cmd_rdy}, 32'd0);
    repeat ($urandom_range(0, 19)) step();
    er = (exp_resp_q.size() > 0) ? exp_resp_q.pop_front() : 8'hxx;
    check("resp", {24'd0, resp}, {24'd0, er});
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 32; i++) tour_mem[i] = 8'h01;

    // 1: reset
    rst_n = 1'b0;
    step();
    step();
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("rst_busy", {31'd0, tour_busy}, 32'd0);
    check("rst_mv_indx", {27'd0, mv_indx}, 32'd0);
    check("rst_resp", {24'd0, resp}, 32'hA5);
    check("rst_err", {31'd0, tour_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // 2: IDLE pass-through
    cmd_UART = 16'h2000;
    cmd_rdy_UART = 1'b1;
    #1;
    check("idle_cmd", {16'd0, cmd}, 32'h2000);
    check("idle_rdy", {31'd0, cmd_rdy}, 32'd1);
    clr_cmd_rdy = 1'b1;
    #1;
    check("idle_clr", {31'd0, clr_cmd_rdy_UART}, 32'd1);
    step();
    clr_cmd_rdy = 1'b0;
    cmd_rdy_UART = 1'b0;
    cmd_UART = 16'h0000;
    #1;

    // 3: directed moves, latency, simultaneous handshakes, reset in HORZ_WT
    tour_mem[0] = 8'h80;
    tour_mem[1] = 8'h10;
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    #1;
    check("lat_state", {29'd0, dbg_state}, {29'd0, S_LATCH});
    check("lat_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("lat_busy", {31'd0, tour_busy}, 32'd1);
    step();
    check("m0_vert", {16'd0, cmd}, 32'h4001);
    check("m0_vert_rdy", {31'd0, cmd_rdy}, 32'd1);
    clr_cmd_rdy = 1'b1;
    send_resp = 1'b1;
    step();
    check("m0_vwt_state", {29'd0, dbg_state}, {29'd0, S_VERT_WT});
    check("m0_vwt_resp", {24'd0, resp}, 32'h5A);
    step();
    check("m0_horz", {16'd0, cmd}, 32'h5BF2);
    check("m0_horz_rdy", {31'd0, cmd_rdy}, 32'd1);
    step();
    check("m0_hwt_state", {29'd0, dbg_state}, {29'd0, S_HORZ_WT});
    check("m0_hwt_resp", {24'd0, resp}, 32'h5A);
    step();
    check("m1_latch", {29'd0, dbg_state}, {29'd0, S_LATCH});
    check("m1_indx", {27'd0, mv_indx}, 32'd1);
    check("m1_latch_rdy", {31'd0, cmd_rdy}, 32'd0);
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    step();
    check("m1_vert", {16'd0, cmd}, 32'h47F2);
    check("m1_vert_rdy", {31'd0, cmd_rdy}, 32'd1);
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    #1;
    check("m1_horz", {16'd0, cmd}, 32'h53F1);
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    #1;
    check("m1_hwt_state", {29'd0, dbg_state}, {29'd0, S_HORZ_WT});
    rst_n = 1'b0;
    send_resp = 1'b1;
    step();
    rst_n = 1'b1;
    send_resp = 1'b0;
    #1;
    check("rst_mid_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    check("rst_mid_indx", {27'd0, mv_indx}, 32'd0);
    check("rst_mid_resp", {24'd0, resp}, 32'hA5);
    check("rst_mid_rdy", {31'd0, cmd_rdy}, 32'd0);
    step();

    // 4: full random tour (multi-hot moves allowed)
    for (int i = 0; i < NUM_MOVES; i++) tour_mem[i] = 8'($urandom_range(1, 255));
    push_tour();
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    for (int k = 0; k < 2 * NUM_MOVES; k++) serve();
    check("full_busy", {31'd0, tour_busy}, 32'd0);
    check("full_indx", {27'd0, mv_indx}, 32'd0);
    check("full_resp", {24'd0, resp}, 32'hA5);
    check("full_q_left", exp_q.size() + exp_resp_q.size(), 32'd0);
    step();

    // 5: UART command arrives mid-tour, held until IDLE
    for (int i = 0; i < NUM_MOVES; i++) begin
      logic [7:0] m;
      m = 8'($urandom_range(1, 255)) & 8'h7B;
      tour_mem[i] = (m == 8'h00) ? 8'h01 : m;
    end
    push_tour();
    mon_en = 1'b1;
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    for (int k = 0; k < 2 * NUM_MOVES; k++) begin
      if (k == 10) begin
        cmd_UART = 16'h4001;
        cmd_rdy_UART = 1'b1;
      end
      serve();
    end
    check("fwd_busy", {31'd0, tour_busy}, 32'd0);
    check("fwd_cmd", {16'd0, cmd}, 32'h4001);
    check("fwd_rdy", {31'd0, cmd_rdy}, 32'd1);
    clr_cmd_rdy = 1'b1;
    #1;
    check("fwd_clr", {31'd0, clr_cmd_rdy_UART}, 32'd1);
    step();
    clr_cmd_rdy = 1'b0;
    cmd_rdy_UART = 1'b0;
    cmd_UART = 16'h0000;
    mon_en = 1'b0;
    exp_q.delete();
    exp_resp_q.delete();
    step();

    // 6: abort on empty move at index 3; start_tour ignored mid-tour
    for (int i = 0; i < 32; i++) tour_mem[i] = 8'h02;
    tour_mem[3] = 8'h00;
    push_tour();
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    serve();
    serve();
    wait_rdy();
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    #1;
    check("ign_start_indx", {27'd0, mv_indx}, 32'd1);
    check("ign_start_rdy", {31'd0, cmd_rdy}, 32'd1);
    for (int k = 0; k < 4; k++) serve();
    check("abort_latch", {29'd0, dbg_state}, {29'd0, S_LATCH});
    check("abort_indx", {27'd0, mv_indx}, 32'd3);
    step();
    check("abort_err", {31'd0, tour_err}, 32'd1);
    check("abort_idle", {31'd0, tour_busy}, 32'd0);
    step();
    check("abort_err_pulse", {31'd0, tour_err}, 32'd0);
    check("abort_rdy", {31'd0, cmd_rdy}, 32'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
